// File: rtl/ahb_periph_mem.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_periph_mem
//  Brief    : Word-organised memory peripheral behind an AHB slave interface.
//             Byte-lane writes, configurable wait states and optional
//             two-cycle ERROR response for out-of-range/misaligned requests
//             (enabled by defining AHB_PMEM_ERR_CHECK_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_periph_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        peripheral_we,
  input  logic        peripheral_re,
  input  logic [31:0] Addr,
  input  logic [1:0]  size,
  input  logic [31:0] wd_data,
  output logic [31:0] peripheral_rd_data,
  output logic        peripheral_ready,
  output logic        peripheral_response
);

  localparam int         c_IDX_W   = $clog2(DEPTH);
  localparam logic [3:0] c_WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef AHB_PMEM_ERR_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;
`else
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 resp_q, resp_d;
  logic [31:0]          rdata_q;
  logic                 we_q;
  logic [c_IDX_W-1:0]   idx_q;
  logic [3:0]           be_q;
  logic [31:0]          wdata_q;
  logic [31:0]          mem_q [DEPTH];

  logic                 w_req;
  logic                 w_err;
  logic [32:0]          w_diff;
  logic [c_IDX_W-1:0]   w_req_idx;
  logic [3:0]           w_req_be;
  logic                 w_capture;
  logic                 w_commit;
  logic                 w_cmt_we;
  logic [c_IDX_W-1:0]   w_cmt_idx;
  logic [3:0]           w_cmt_be;
  logic [31:0]          w_cmt_wdata;
  logic                 w_unused_bits;

  // Offset from the base; bit 32 is the borrow (address below the window).
  assign w_diff        = {1'b0, Addr} - {1'b0, BASE_ADDR};
  assign w_req_idx     = w_diff[c_IDX_W+1:2];
  assign w_req         = peripheral_we | peripheral_re;
  assign w_unused_bits = ^{w_diff[32:c_IDX_W+2], w_diff[1:0]};

  // Byte-lane enables derived from size and the low address bits.
  always_comb begin
    w_req_be = 4'b1111;
    case (size)
      2'b00:   w_req_be = 4'b0001 << Addr[1:0];
      2'b01:   w_req_be = Addr[1] ? 4'b1100 : 4'b0011;
      default: w_req_be = 4'b1111;
    endcase
  end

`ifdef AHB_PMEM_ERR_CHECK_EN
  // Range and alignment check of the incoming request.
  always_comb begin
    w_err = 1'b0;
    if (w_diff[32] || (|w_diff[31:c_IDX_W+2])) w_err = 1'b1;
    if (size == 2'b11)                         w_err = 1'b1;
    if (size == 2'b01 && Addr[0])              w_err = 1'b1;
    if (size == 2'b10 && Addr[1:0] != 2'b00)   w_err = 1'b1;
  end
`else
  assign w_err = 1'b0;
`endif

  // With zero wait states the access commits straight from the request inputs.
  assign w_cmt_we    = (state_q == S_WAIT) ? we_q    : peripheral_we;
  assign w_cmt_idx   = (state_q == S_WAIT) ? idx_q   : w_req_idx;
  assign w_cmt_be    = (state_q == S_WAIT) ? be_q    : w_req_be;
  assign w_cmt_wdata = (state_q == S_WAIT) ? wdata_q : wd_data;

  // Next-state, wait counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b1;
    resp_d    = 1'b0;
    w_capture = 1'b0;
    w_commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          if (w_err) begin
`ifdef AHB_PMEM_ERR_CHECK_EN
            state_d = S_ERR1;
            ready_d = 1'b0;
            resp_d  = 1'b1;
`endif
          end else if (WAIT_STATES == 0) begin
            w_commit = 1'b1;
          end else begin
            state_d   = S_WAIT;
            cnt_d     = c_WS_LOAD;
            ready_d   = 1'b0;
            w_capture = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          ready_d = 1'b0;
        end else begin
          w_commit = 1'b1;
          state_d  = S_IDLE;
        end
      end
`ifdef AHB_PMEM_ERR_CHECK_EN
      S_ERR1: begin
        state_d = S_ERR2;
        resp_d  = 1'b1;
      end
      S_ERR2: begin
        state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Control/state registers, request capture and read-data register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
      if (w_capture) begin
        we_q    <= peripheral_we;
        idx_q   <= w_req_idx;
        be_q    <= w_req_be;
        wdata_q <= wd_data;
      end
      if (w_commit && !w_cmt_we) rdata_q <= mem_q[w_cmt_idx];
    end
  end

  // Memory array: byte-lane write on commit, contents are not reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET && w_commit && w_cmt_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cmt_be[b]) mem_q[w_cmt_idx][8*b +: 8] <= w_cmt_wdata[8*b +: 8];
      end
    end
  end

  assign peripheral_rd_data  = rdata_q;
  assign peripheral_ready    = ready_q;
  assign peripheral_response = resp_q;

endmodule
`default_nettype wire

// File: doc/ahb_periph_mem.md
# ahb_periph_mem

Word-organised memory peripheral that sits directly downstream of the AHB slave interface. It consumes that interface's strobed requests (`peripheral_we`, `peripheral_re`, `Addr`, `size`, `wd_data`) and performs the access with a configurable number of wait states and byte-lane writes. It returns `peripheral_rd_data`, `peripheral_ready` and `peripheral_response` to the interface. It also flags out-of-range and misaligned accesses with a two-cycle AHB-style ERROR response.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be DEPTH*4-aligned.
- `DEPTH`, default 256: number of 32-bit words; power of 2, minimum 4.
- `WAIT_STATES`, default 2: cycles `peripheral_ready` is held low per OKAY access; range 0..15.
- `HCLK`, in, 1: clock; all state changes on the rising edge.
- `HRESET`, in, 1: reset, synchronous, active-high.
- `peripheral_we`, in, 1: write request strobe.
- `peripheral_re`, in, 1: read request strobe.
- `Addr`, in, 32: byte address.
- `size`, in, 2: transfer size. 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `wd_data`, in, 32: write data, AHB lane-aligned.
- `peripheral_rd_data`, out, 32: read data word.
- `peripheral_ready`, out, 1: 1 = idle or transfer complete; 0 = wait.
- `peripheral_response`, out, 1: 0 = OKAY, 1 = ERROR.

## Operation
- **States:** IDLE, WAIT, ERR1, ERR2. All outputs are registered.
- **Request:** `peripheral_we` or `peripheral_re` is sampled high in IDLE.
  - If both are high, the request is a write.
  - On accept, `Addr`, `size`, `wd_data` and the direction are captured.
- **Error check** (only with the macro, see Configuration). The request is in error if any of these hold:
  - `Addr` < BASE_ADDR.
  - `Addr` >= BASE_ADDR + DEPTH*4.
  - `size` == 11.
  - `size` == 01 and `Addr[0]` = 1.
  - `size` == 10 and `Addr[1:0]` != 0.
- **Word index:** (`Addr` − BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- **Write lanes:**
  - Byte: lane `Addr[1:0]`.
  - Halfword: lanes {`Addr[1]`*2, +1}.
  - Word: all four lanes.
  - Unselected bytes are unchanged.
- **Read:** returns the full word at the index; the interconnect selects lanes.
- **Transitions:**
  - IDLE, error request → ERR1.
  - IDLE, OKAY request, WAIT_STATES = 0 → access commits this edge; stay in IDLE.
  - IDLE, OKAY request, WAIT_STATES > 0 → WAIT, counter loaded with WAIT_STATES−1.
  - WAIT, counter ≠ 0 → decrement.
  - WAIT, counter = 0 → commit the access, → IDLE.
  - ERR1 → ERR2 → IDLE.
- Requests arriving in WAIT, ERR1 or ERR2 are ignored; upstream must not issue them.
- An errored request never modifies memory or `peripheral_rd_data`.

## Timing
- **Reset values:**
  - `peripheral_ready` = 1, `peripheral_response` = 0, `peripheral_rd_data` = 0, state = IDLE, counter = 0.
  - Memory contents are not reset.
- **Reset mid-operation:** returns to IDLE the next edge. A pending write in WAIT is discarded.
- **OKAY access, request sampled at edge T:**
  - `peripheral_ready` is 0 for edges T+1..T+WAIT_STATES.
  - It returns to 1 at edge T+WAIT_STATES+1.
  - Write commit and `peripheral_rd_data` update happen on that same edge.
- **WAIT_STATES = 0:** `peripheral_ready` stays 1. The write commits, or read data appears, at edge T+1.
- **ERROR response:**
  - Edge T+1: `peripheral_ready` = 0, `peripheral_response` = 1.
  - Edge T+2: `peripheral_ready` = 1, `peripheral_response` = 1.
  - Edge T+3: `peripheral_response` = 0.
- `peripheral_rd_data` holds its last value between reads and across writes.
- **Back-to-back requests:** the next request is accepted in the cycle after `peripheral_ready` returns to 1 with `peripheral_response` = 0. With WAIT_STATES = 0, one access per cycle.
- **Read after write to the same word:** returns the new data, provided the read is accepted after the write's commit edge.

## Configuration
- Macro: `AHB_PMEM_ERR_CHECK_EN`.
- **Defined:** error checking as described; ERR1 and ERR2 are reachable.
- **Undefined:**
  - No error checking; `peripheral_response` is constant 0 and ERR1/ERR2 are removed.
  - Out-of-range addresses wrap modulo DEPTH words.
  - `size` = 11 is treated as a word access.
  - Misaligned halfword and word accesses use the lanes from `Addr` bits as given.

## Test plan
- **Reset:** assert `HRESET` for 2 cycles → `peripheral_ready` = 1, `peripheral_response` = 0, `peripheral_rd_data` = 0.
- **Word write/read, WAIT_STATES = 2:**
  - Stimulus: write 32'hDEAD_BEEF to BASE+8, then read BASE+8.
  - Response: ready low exactly 2 cycles per access; read data = 32'hDEAD_BEEF.
- **Byte lanes:**
  - Stimulus: write word 32'h1122_3344 to BASE+4; byte write 32'hAA00_0000 at BASE+7; halfword write 32'h0000_5566 at BASE+4; read BASE+4.
  - Response: read data = 32'hAA22_5566.
- **Error, macro defined:**
  - Stimulus: word write at BASE+2, then read at BASE+DEPTH*4.
  - Response: each gives ready 0/1 with response 1/1 over 2 cycles; memory and `peripheral_rd_data` unchanged.
- **Reset mid-WAIT:**
  - Stimulus: write 32'h1234_5678 to BASE+0 (old value 0), assert `HRESET` in the first WAIT cycle, then read BASE+0.
  - Response: ready = 1 the cycle after reset; read returns 0.
- **WAIT_STATES = 0 and simultaneous strobes:**
  - Stimulus: `peripheral_we` = `peripheral_re` = 1 at BASE+12 with data 32'hCAFE_F00D, then read BASE+12.
  - Response: ready never drops; the first request is a write; read returns 32'hCAFE_F00D one cycle later.
